// File: rtl/riscv_defines.sv
// Shared RISC-V core definitions: store width encoding and helpers used by the
// store/load lane logic.
package riscv_defines;

  typedef enum logic [1:0] {
    STORE_OP_SB = 2'b00,
    STORE_OP_SH = 2'b01,
    STORE_OP_SW = 2'b10
  } StoreOp_t;

  // Byte-enable pattern before lane shifting; unknown encodings act as SB.
  function automatic logic [3:0] store_base_mask(input StoreOp_t op);
    case (op)
      STORE_OP_SH: store_base_mask = 4'b0011;
      STORE_OP_SW: store_base_mask = 4'b1111;
      default:     store_base_mask = 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_lane_align.sv
// Combinational byte-lane alignment: shifts store data and strobe across a
// 64-bit window spanning two words and flags word-crossing accesses.
module store_lane_align
  import riscv_defines::*;
(
  input  StoreOp_t    i_store_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  output logic [63:0] o_data,
  output logic [7:0]  o_strb,
  output logic        o_split
);

  logic [3:0] w_mask;

  assign w_mask  = store_base_mask(i_store_op);
  assign o_data  = {32'd0, i_store_data} << {i_off, 3'b000};
  assign o_strb  = {4'd0, w_mask} << i_off;
  assign o_split = |o_strb[7:4];

endmodule

// File: rtl/store_unit.sv
// Memory-stage store unit: issues byte-lane-aligned word writes, splitting
// word-crossing stores into two beats or faulting them.
//
//  state   | meaning
//  IDLE    | waiting for a store; faults misaligned ones when splitting is off
//  LO      | low-word beat on the memory port
//  HI      | high-word beat of a split store
module store_unit
  import riscv_defines::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_valid,
  input  StoreOp_t    StoreOpD,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  output logic        store_done,
  output logic        misaligned_fault,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10
  } store_unit_state_t;

  store_unit_state_t r_state, w_next;

  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_split;
  logic        w_accept;

  logic [29:0] r_addr_lo;
  logic [29:0] r_addr_hi;
  logic [31:0] r_wdata_lo;
  logic [31:0] r_wdata_hi;
  logic [3:0]  r_strb_lo;
  logic [3:0]  r_strb_hi;
  logic        r_split;

  store_lane_align u_align (
    .i_store_op   (StoreOpD),
    .i_off        (store_addr[1:0]),
    .i_store_data (store_data),
    .o_data       (w_data),
    .o_strb       (w_strb),
    .o_split      (w_split)
  );

  assign w_accept = (r_state == ST_IDLE) && store_valid && (!w_split || ALLOW_MISALIGNED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr_lo  <= '0;
      r_addr_hi  <= '0;
      r_wdata_lo <= '0;
      r_wdata_hi <= '0;
      r_strb_lo  <= '0;
      r_strb_hi  <= '0;
      r_split    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr_lo  <= store_addr[31:2];
        r_addr_hi  <= store_addr[31:2] + 30'd1;
        r_wdata_lo <= w_data[31:0];
        r_wdata_hi <= w_data[63:32];
        r_strb_lo  <= w_strb[3:0];
        r_strb_hi  <= w_strb[7:4];
        r_split    <= w_split;
      end
    end
  end

  always_comb begin
    w_next           = r_state;
    store_done       = 1'b0;
    misaligned_fault = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_LO;
        end else if (store_valid && w_split && !ALLOW_MISALIGNED) begin
          misaligned_fault = 1'b1;
        end
      end
      ST_LO: begin
        if (mem_ready) begin
          if (r_split) begin
            w_next = ST_HI;
          end else begin
            store_done = 1'b1;
            w_next     = ST_IDLE;
          end
        end
      end
      ST_HI: begin
        if (mem_ready) begin
          store_done = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Reset wins: no completion or fault may escape in the reset cycle.
    if (rst) begin
      store_done       = 1'b0;
      misaligned_fault = 1'b0;
    end
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (r_state)
      ST_LO: begin
        mem_valid = 1'b1;
        mem_addr  = {r_addr_lo, 2'b00};
        mem_wdata = r_wdata_lo;
        mem_wstrb = r_strb_lo;
      end
      ST_HI: begin
        mem_valid = 1'b1;
        mem_addr  = {r_addr_hi, 2'b00};
        mem_wdata = r_wdata_hi;
        mem_wstrb = r_strb_hi;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: table of single stores plus hand sequences
// for fault, backpressure and reset during a split store.
module tb_store_unit;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_valid_a, store_valid_b;
  StoreOp_t    op;
  logic [31:0] addr, data;
  logic        mem_ready_a, mem_ready_b;

  logic        done_a, fault_a, mvalid_a;
  logic [31:0] maddr_a, mwdata_a;
  logic [3:0]  mstrb_a;
  logic        done_b, fault_b, mvalid_b;
  logic [31:0] maddr_b, mwdata_b;
  logic [3:0]  mstrb_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_unit #(.ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .store_valid(store_valid_a), .StoreOpD(op),
    .store_addr(addr), .store_data(data), .store_done(done_a),
    .misaligned_fault(fault_a), .mem_valid(mvalid_a), .mem_ready(mem_ready_a),
    .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_wstrb(mstrb_a)
  );

  store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .store_valid(store_valid_b), .StoreOpD(op),
    .store_addr(addr), .store_data(data), .store_done(done_b),
    .misaligned_fault(fault_b), .mem_valid(mvalid_b), .mem_ready(mem_ready_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_wstrb(mstrb_b)
  );

  typedef struct {
    StoreOp_t    op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        split;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    op = v.op; addr = v.addr; data = v.data;
    store_valid_a = 1'b1; mem_ready_a = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d accept mem_valid", i), 32'(mvalid_a), 32'd0);
    chk($sformatf("v%0d accept done", i), 32'(done_a), 32'd0);
    next_cycle();
    @(negedge clk);
    chk($sformatf("v%0d b0 mem_valid", i), 32'(mvalid_a), 32'd1);
    chk($sformatf("v%0d b0 addr", i), maddr_a, v.a0);
    chk($sformatf("v%0d b0 wdata", i), mwdata_a, v.d0);
    chk($sformatf("v%0d b0 wstrb", i), 32'(mstrb_a), 32'(v.s0));
    chk($sformatf("v%0d b0 done", i), 32'(done_a), 32'(!v.split));
    if (v.split) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("v%0d b1 mem_valid", i), 32'(mvalid_a), 32'd1);
      chk($sformatf("v%0d b1 addr", i), maddr_a, v.a1);
      chk($sformatf("v%0d b1 wdata", i), mwdata_a, v.d1);
      chk($sformatf("v%0d b1 wstrb", i), 32'(mstrb_a), 32'(v.s1));
      chk($sformatf("v%0d b1 done", i), 32'(done_a), 32'd1);
    end
    next_cycle();
    store_valid_a = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d idle mem_valid", i), 32'(mvalid_a), 32'd0);
    chk($sformatf("v%0d idle addr", i), maddr_a, 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{STORE_OP_SW, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0, 4'h0};
    vecs[1] = '{STORE_OP_SB, 32'h0000_1003, 32'h1234_56AB, 1'b0, 32'h0000_1000, 32'hAB00_0000, 4'h8, 32'h0, 32'h0, 4'h0};
    vecs[2] = '{STORE_OP_SH, 32'h0000_1003, 32'h0000_1234, 1'b1, 32'h0000_1000, 32'h3400_0000, 4'h8, 32'h0000_1004, 32'h0000_0012, 4'h1};
    vecs[3] = '{STORE_OP_SH, 32'h0000_2002, 32'hABCD_5678, 1'b0, 32'h0000_2000, 32'h5678_0000, 4'hC, 32'h0, 32'h0, 4'h0};
    vecs[4] = '{STORE_OP_SW, 32'hFFFF_FFFE, 32'h1122_3344, 1'b1, 32'hFFFF_FFFC, 32'h3344_0000, 4'hC, 32'h0000_0000, 32'h0000_1122, 4'h3};
    vecs[5] = '{STORE_OP_SW, 32'h0000_4001, 32'hA1B2_C3D4, 1'b1, 32'h0000_4000, 32'hB2C3_D400, 4'hE, 32'h0000_4004, 32'h0000_00A1, 4'h1};
    vecs[6] = '{StoreOp_t'(2'b11), 32'h0000_5002, 32'h0000_00EE, 1'b0, 32'h0000_5000, 32'h00EE_0000, 4'h4, 32'h0, 32'h0, 4'h0};
    vecs[7] = '{STORE_OP_SH, 32'h0000_6000, 32'h0000_BEEF, 1'b0, 32'h0000_6000, 32'h0000_BEEF, 4'h3, 32'h0, 32'h0, 4'h0};
    vecs[8] = '{STORE_OP_SB, 32'h0000_3001, 32'h0000_00CC, 1'b0, 32'h0000_3000, 32'h0000_CC00, 4'h2, 32'h0, 32'h0, 4'h0};

    // Reset with a misaligned store pending on the faulting instance.
    rst = 1'b1; store_valid_a = 1'b0; store_valid_b = 1'b1;
    op = STORE_OP_SW; addr = 32'h0000_1002; data = 32'h0;
    mem_ready_a = 1'b1; mem_ready_b = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst fault forced low", 32'(fault_b), 32'd0);
    chk("rst done forced low", 32'(done_b), 32'd0);
    next_cycle();
    rst = 1'b0; store_valid_b = 1'b0;
    @(negedge clk);
    chk("post-rst mem_valid", 32'(mvalid_a), 32'd0);
    chk("post-rst mem_addr", maddr_a, 32'd0);
    chk("post-rst mem_wdata", mwdata_a, 32'd0);
    chk("post-rst mem_wstrb", 32'(mstrb_a), 32'd0);
    chk("post-rst done", 32'(done_a), 32'd0);
    chk("post-rst fault", 32'(fault_a), 32'd0);
    next_cycle();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Faulting instance: misaligned SW.
    op = STORE_OP_SW; addr = 32'h0000_1002; data = 32'h1111_2222;
    store_valid_b = 1'b1;
    @(negedge clk);
    chk("fault pulse", 32'(fault_b), 32'd1);
    chk("fault mem_valid", 32'(mvalid_b), 32'd0);
    chk("fault done", 32'(done_b), 32'd0);
    next_cycle();
    store_valid_b = 1'b0;
    @(negedge clk);
    chk("fault cleared", 32'(fault_b), 32'd0);
    chk("fault no traffic", 32'(mvalid_b), 32'd0);
    next_cycle();
    // Faulting instance still handles aligned stores normally.
    addr = 32'h0000_1000; store_valid_b = 1'b1;
    @(negedge clk);
    chk("b aligned no fault", 32'(fault_b), 32'd0);
    next_cycle();
    store_valid_b = 1'b0;
    @(negedge clk);
    chk("b aligned mem_valid", 32'(mvalid_b), 32'd1);
    chk("b aligned wstrb", 32'(mstrb_b), 32'hF);
    chk("b aligned done", 32'(done_b), 32'd1);
    next_cycle();

    // Backpressure; input changes while busy must be ignored.
    op = STORE_OP_SW; addr = 32'h0000_2000; data = 32'h55AA_55AA;
    store_valid_a = 1'b1; mem_ready_a = 1'b0;
    @(negedge clk);
    chk("bp accept mem_valid", 32'(mvalid_a), 32'd0);
    next_cycle();
    addr = 32'h0000_2FF3; data = 32'h0; op = STORE_OP_SB;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready_a = 1'b1;
      @(negedge clk);
      chk($sformatf("bp c%0d mem_valid", c), 32'(mvalid_a), 32'd1);
      chk($sformatf("bp c%0d addr", c), maddr_a, 32'h0000_2000);
      chk($sformatf("bp c%0d wdata", c), mwdata_a, 32'h55AA_55AA);
      chk($sformatf("bp c%0d wstrb", c), 32'(mstrb_a), 32'hF);
      chk($sformatf("bp c%0d done", c), 32'(done_a), (c == 3) ? 32'd1 : 32'd0);
      next_cycle();
      if (c == 3) store_valid_a = 1'b0;
    end
    @(negedge clk);
    chk("bp idle mem_valid", 32'(mvalid_a), 32'd0);
    next_cycle();

    // Reset during the HI beat of a split store.
    op = STORE_OP_SH; addr = 32'h0000_1003; data = 32'h0000_1234;
    store_valid_a = 1'b1; mem_ready_a = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst-hi addr", maddr_a, 32'h0000_1004);
    chk("rst-hi done forced", 32'(done_a), 32'd0);
    next_cycle();
    rst = 1'b0; store_valid_a = 1'b0;
    @(negedge clk);
    chk("rst-hi mem_valid drop", 32'(mvalid_a), 32'd0);
    chk("rst-hi no done", 32'(done_a), 32'd0);
    next_cycle();
    run_vec(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Memory-stage store unit: consumes the `StoreOp_t` produced by `store_decoder`, together with the effective address and rs2 data, and issues byte-lane-aligned word writes on the data-memory request port. Word-crossing (misaligned) halfword and word stores are split into two word transactions, or reported as a fault, depending on a parameter. While a store is outstanding the unit signals completion only on its final beat, which lets the pipeline hold the MEM stage.

## Interface

- `ALLOW_MISALIGNED`, default 1: 1 splits word-crossing stores into two beats; 0 reports them on `misaligned_fault` and issues no memory traffic.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `store_valid`  in  1  MEM stage holds a store. Held, with all inputs stable, until `store_done` or `misaligned_fault`.
- `StoreOpD`  in  `StoreOp_t`  store width: `STORE_OP_SB`, `STORE_OP_SH` or `STORE_OP_SW`. Any other encoding is treated as SB.
- `store_addr`  in  32  byte address.
- `store_data`  in  32  rs2 value; only the low 8 or 16 bits are significant for SB or SH.
- `store_done`  out  1  combinational; high in the cycle the final beat handshakes.
- `misaligned_fault`  out  1  combinational single-cycle pulse; see Operation.
- `mem_valid`  out  1  request valid.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_addr`  out  32  word address, bits [1:0] always 0.
- `mem_wdata`  out  32  lane-shifted write data.
- `mem_wstrb`  out  4  byte enables.

## Operation

**Lane alignment**
- `off = store_addr[1:0]`.
- Base mask: SB = 0x1, SH = 0x3, SW = 0xF.
- 8-bit strobe = base mask << `off`.
- 64-bit data = zero-extended `store_data` << (8·`off`).
- Low beat uses bits [31:0] and strobe [3:0].
- High beat uses bits [63:32] and strobe [7:4], at address `{store_addr[31:2],2'b00} + 4`.
- `split` = (strobe[7:4] != 0).

**State machine: IDLE, LO, HI**
- IDLE with `store_valid`, and either `!split` or `ALLOW_MISALIGNED = 1`: capture both beats' address, data and strobe, and `split`; go to LO.
- IDLE with `store_valid`, `split` and `ALLOW_MISALIGNED = 0`: assert `misaligned_fault` that cycle, capture nothing, stay in IDLE. The upstream logic treats the fault as completion (it raises the trap).
- LO: `mem_valid = 1`, low-beat payload.
  - On `mem_ready`: if `split`, go to HI; otherwise `store_done = 1` and go to IDLE.
- HI: `mem_valid = 1`, high-beat payload.
  - On `mem_ready`: `store_done = 1`, go to IDLE.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are driven from registers only. When `mem_valid` is 0 they are driven to 0.
- The registered payload stays stable while `mem_valid && !mem_ready` (backpressure of any length).

## Timing

**Reset**
- While `rst` is high at a clock edge, the state becomes IDLE and all payload registers clear.
- In the cycle `rst` is high, `store_done` and `misaligned_fault` are forced to 0.
- After reset: `mem_valid = 0`, `mem_addr = 0`, `mem_wdata = 0`, `mem_wstrb = 0`, `store_done = 0`, `misaligned_fault = 0`.

**Latency and throughput**
- Acceptance edge to first `mem_valid`: 1 cycle.
- Aligned store with `mem_ready` tied high: `store_done` in cycle 2, counting the acceptance cycle as 1.
- Split store with `mem_ready` tied high: `store_done` in cycle 3.
- Aligned stores issue at most one every 2 cycles.
- After `store_done`, the IDLE state may accept a new `store_valid` in the very next cycle.

**Boundary conditions**
- `store_valid` is ignored outside IDLE. It is not re-sampled, and the captured payload is used.
- Reset mid-transaction (LO or HI, including under backpressure): `mem_valid` drops in the cycle after the reset edge and no `store_done` is produced. The memory side shares this reset and discards the partial request.
- A fault and a memory request never occur in the same cycle.
- `mem_wstrb` is never 0 while `mem_valid` is 1.
- `store_addr` = 0xFFFFFFFE with SW: the high beat address wraps to 0x00000000.

## Structure

- `StoreOp_t` and the `STORE_OP_*` constants stay in the shared `riscv_defines` package.
- The three-state typedef `store_unit_state_t` is local to this module.
- Sub-module `store_lane_align` is purely combinational:
  - inputs: `StoreOpD`, `off`, `store_data`;
  - outputs: 64-bit shifted data, 8-bit strobe, `split`.
  - It can be reused by the load path for mask generation.
- The FSM and payload registers live in `store_unit`.

## Test plan

- **Aligned SW:** SW at 0x1000, data 0xDEADBEEF, `mem_ready` = 1 → one beat: addr 0x1000, wstrb 0xF, wdata 0xDEADBEEF; `store_done` in cycle 2.
- **SB at top byte:** SB at 0x1003, data 0x123456AB → addr 0x1000, wstrb 0x8, wdata 0xAB000000.
- **Split SH (`ALLOW_MISALIGNED` = 1):** SH at 0x1003, data 0x00001234 →
  - beat 0: addr 0x1000, wstrb 0x8, wdata 0x34000000;
  - beat 1: addr 0x1004, wstrb 0x1, wdata 0x00000012;
  - `store_done` only on beat 1.
- **Fault (`ALLOW_MISALIGNED` = 0):** SW at 0x1002 → `misaligned_fault` high for 1 cycle; `mem_valid` stays 0; state stays IDLE.
- **Backpressure:** SW at 0x2000 with `mem_ready` = 0 for 3 cycles → `mem_valid`, addr, wdata and wstrb are constant across all 4 cycles; `store_done` only in the 4th.
- **Reset mid-split:** `rst` asserted during the HI beat of a split store → `mem_valid = 0` and `store_done = 0` in the following cycle. A subsequent aligned SB at 0x3001, data 0xCC, gives addr 0x3000, wstrb 0x2, wdata 0x0000CC00.
